herzel_sequencer: RTL
=====================

// Module: herzel_sequencer
// PURPOSE
//  Control FSM for the Goertzel (Herzel) filter bank. On a start command it runs one shared
//  CORDIC once per channel to produce the coefficient 2*cos(w), writes each coefficient into
//  its core, then gates an NS-sample acquisition window. It waits for every core's result
//  valid and raises the status bits that the SPI register bank reports in STATUS.
//  Sits between the register bank (FREQ_n, EN_CORDIC, STATUS) and the NF Herzel core instances.
// PARAMETERS
//  NF        11        number of frequency channels / Herzel cores
//  NS        100000    samples per acquisition window
//  DRAIN_TMO 1024      max cycles in DRAIN waiting for all core_valid before err
//  IW        $clog2(NF) channel index width (local, derived)
// PORTS
//  clk          in   1      system clock
//  rstn         in   1      synchronous reset, active low
//  start        in   1      1-cycle pulse: EN_CORDIC written with 1
//  abort        in   1      1-cycle pulse: return to IDLE from any state
//  freq_idx     out  IW     channel whose FREQ register is presented on freq_data
//  freq_data    in   32     phase argument of channel freq_idx (combinational from reg bank)
//  cordic_req   out  1      request; held until cordic_ack
//  cordic_arg   out  32     argument, valid while cordic_req
//  cordic_ack   in   1      1-cycle: cordic_cos valid
//  cordic_cos   in   32     cos(arg), signed Q1.30
//  coef_we      out  1      1-cycle coefficient write strobe
//  coef_idx     out  IW     target core of coef_we
//  coef_data    out  32     2*cos, signed Q1.30 saturated
//  sample_en    in   1      external acquisition enable (enable_p)
//  core_clear   out  1      1-cycle clear of all core accumulators
//  core_run     out  1      cores accept a sample this cycle
//  core_valid   in   NF     per-core result valid (level)
//  stat_coef    out  1      STATUS_CORDIC: all coefficients loaded
//  stat_all     out  1      STATUS_HERZEL_ALL: all cores valid
//  stat_err     out  1      drain timeout or abort since last start
//  busy         out  1      state != IDLE && state != DONE
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; counters 0. All outputs are registered.
//  IDLE: start -> CREQ with idx=0, stat_coef/stat_all/stat_err cleared. start is ignored in
//   every other state except DONE.
//  CREQ: cordic_req=1, cordic_arg=freq_data at idx (registered on entry) -> CWAIT.
//  CWAIT: hold req/arg. On cordic_ack: coef_we=1 for 1 cycle, coef_idx=idx,
//   coef_data = (cos==32'h4000_0000) ? 32'h7FFF_FFFF : cos<<<1.
//   Then if idx==NF-1 -> ARMED, else idx++ -> CREQ.
//   Request-to-request gap is 1 cycle minimum.
//  ARMED: stat_coef=1. core_clear pulses on the first cycle in ARMED.
//   sample_en rising (registered 0 -> 1) -> RUN. core_run asserts on the same cycle the
//   sample is presented.
//  RUN: core_run=sample_en. scnt increments on each core_run cycle.
//   The run with scnt==NS-1 is the last one -> DRAIN; core_run=0 from then on.
//   sample_en low pauses counting; it does not abort.
//  DRAIN: tcnt++. &core_valid -> DONE with stat_all=1.
//   tcnt==DRAIN_TMO-1 -> DONE with stat_err=1, stat_all=0.
//  DONE: status bits held; start -> CREQ (restart, bits cleared); sample_en ignored.
//  abort (priority over all transitions, including a coinciding start or ack): -> IDLE,
//   cordic_req dropped, core_run=0, stat_err=1, stat_coef/stat_all=0. A late cordic_ack in
//   IDLE is ignored (no coef_we).
//  Simultaneous ack and last sample are impossible by construction (distinct states).
//  scnt width $clog2(NS+1); no wrap: NS is the terminal count.
// STRUCTURE
//  herzel_pkg: typedef enum logic[2:0] {IDLE,CREQ,CWAIT,ARMED,RUN,DRAIN,DONE} hseq_state_t;
//   localparam COEF_SAT=32'h7FFF_FFFF, COS_ONE=32'h4000_0000;
//   STATUS_CORDIC_MSK/STATUS_HERZEL_ALL_MSK bit positions.
//  One sub-module: herzel_coef_sat (cos -> 2cos, saturating, combinational).
//  Rest is a single FSM plus idx/scnt/tcnt counters.
// TESTING (bench NF=3, NS=8, DRAIN_TMO=16, CORDIC model ack 4 cycles after req)
//  1 freq={100,200,300}, start -> 3 req with arg 100,200,300; 3 coef_we idx 0,1,2;
//    stat_coef=1 after the 3rd.
//  2 cordic_cos=32'h4000_0000 -> coef_data=32'h7FFF_FFFF; cos=32'hC000_0000 -> 32'h8000_0000.
//  3 sample_en high 8 cycles with 2-cycle gap after the 3rd -> exactly 8 core_run cycles;
//    core_valid=3'b111 -> stat_all=1, busy=0.
//  4 core_valid stuck 3'b011 -> DONE after 16 DRAIN cycles, stat_err=1, stat_all=0.
//  5 abort during CWAIT with coinciding ack -> IDLE, no coef_we, stat_err=1;
//    new start clears stat_err and restarts at idx 0.
//  6 rstn=0 mid-RUN for 1 cycle -> all outputs 0, state IDLE; sample_en ignored until start.

Source files
------------

// File: rtl/herzel_pkg.sv
// Shared types and constants for the Herzel filter-bank sequencer.
package herzel_pkg;

  typedef enum logic [2:0] {IDLE, CREQ, CWAIT, ARMED, RUN, DRAIN, DONE} hseq_state_t;

  // Plain-vector aliases of the state encoding, used by the FSM register and debug port.
  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_CREQ  = CREQ;
  localparam logic [2:0] S_CWAIT = CWAIT;
  localparam logic [2:0] S_ARMED = ARMED;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_DONE  = DONE;

  localparam logic [31:0] COEF_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] COS_ONE  = 32'h4000_0000;

  // STATUS register bit positions and masks as reported by the register bank.
  localparam int STATUS_CORDIC_BIT     = 0;
  localparam int STATUS_HERZEL_ALL_BIT = 1;
  localparam logic [7:0] STATUS_CORDIC_MSK     = 8'h01;
  localparam logic [7:0] STATUS_HERZEL_ALL_MSK = 8'h02;

endpackage

// File: rtl/herzel_coef_sat.sv
// cos(w) -> 2*cos(w) in Q1.30; +1.0 is the only input whose double is unrepresentable.
module herzel_coef_sat
  import herzel_pkg::*;
(
  input  logic [31:0] cos_in,
  output logic [31:0] coef_out
);

  always_comb begin
    coef_out = (cos_in == COS_ONE) ? COEF_SAT : {cos_in[30:0], 1'b0};
  end

endmodule

// File: rtl/herzel_sequencer.sv
// Herzel sequencer: loads one CORDIC-derived coefficient per channel, gates an NS-sample
// acquisition window, then waits for all cores. Handshake: cordic_req is held with cordic_arg
// stable until a 1-cycle cordic_ack; core_valid is a level per core. All outputs registered.
module herzel_sequencer
  import herzel_pkg::*;
#(
  parameter int NF        = 11,
  parameter int NS        = 100000,
  parameter int DRAIN_TMO = 1024,
  localparam int IW       = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  output logic [IW-1:0] freq_idx,
  input  logic [31:0]   freq_data,
  output logic          cordic_req,
  output logic [31:0]   cordic_arg,
  input  logic          cordic_ack,
  input  logic [31:0]   cordic_cos,
  output logic          coef_we,
  output logic [IW-1:0] coef_idx,
  output logic [31:0]   coef_data,
  input  logic          sample_en,
  output logic          core_clear,
  output logic          core_run,
  input  logic [NF-1:0] core_valid,
  output logic          stat_coef,
  output logic          stat_all,
  output logic          stat_err,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  localparam int SW = $clog2(NS + 1);
  localparam int TW = $clog2(DRAIN_TMO + 1);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          sample_en_q;
  logic          req_q, req_d;
  logic [31:0]   arg_q, arg_d;
  logic          coef_we_q, coef_we_d;
  logic [IW-1:0] coef_idx_q, coef_idx_d;
  logic [31:0]   coef_data_q, coef_data_d;
  logic          core_clear_q, core_clear_d;
  logic          core_run_q, core_run_d;
  logic          stat_coef_q, stat_coef_d;
  logic          stat_all_q, stat_all_d;
  logic          stat_err_q, stat_err_d;
  logic          busy_q, busy_d;
  logic [31:0]   sat_coef;
  logic          accept;

  herzel_coef_sat u_coef_sat (
    .cos_in   (cordic_cos),
    .coef_out (sat_coef)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    scnt_d       = scnt_q;
    tcnt_d       = tcnt_q;
    req_d        = req_q;
    arg_d        = arg_q;
    coef_we_d    = 1'b0;
    coef_idx_d   = coef_idx_q;
    coef_data_d  = coef_data_q;
    core_clear_d = 1'b0;
    core_run_d   = 1'b0;
    stat_coef_d  = stat_coef_q;
    stat_all_d   = stat_all_q;
    stat_err_d   = stat_err_q;
    // The first sample is taken on the registered rising edge; later ones on the level.
    accept       = (state_q == S_ARMED) ? (sample_en && !sample_en_q) : sample_en;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_CREQ;
          idx_d       = '0;
          stat_coef_d = 1'b0;
          stat_all_d  = 1'b0;
          stat_err_d  = 1'b0;
        end
      end
      S_CREQ: begin
        req_d   = 1'b1;
        arg_d   = freq_data;
        state_d = S_CWAIT;
      end
      S_CWAIT: begin
        if (cordic_ack) begin
          req_d       = 1'b0;
          coef_we_d   = 1'b1;
          coef_idx_d  = idx_q;
          coef_data_d = sat_coef;
          if (idx_q == IW'(NF - 1)) begin
            state_d      = S_ARMED;
            stat_coef_d  = 1'b1;
            core_clear_d = 1'b1;
            scnt_d       = '0;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_CREQ;
          end
        end
      end
      S_ARMED, S_RUN: begin
        if (accept) begin
          core_run_d = 1'b1;
          scnt_d     = scnt_q + SW'(1);
          tcnt_d     = '0;
          state_d    = (scnt_q == SW'(NS - 1)) ? S_DRAIN : S_RUN;
        end
      end
      S_DRAIN: begin
        tcnt_d = tcnt_q + TW'(1);
        if (&core_valid) begin
          state_d    = S_DONE;
          stat_all_d = 1'b1;
        end else if (tcnt_q == TW'(DRAIN_TMO - 1)) begin
          state_d    = S_DONE;
          stat_all_d = 1'b0;
          stat_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      req_d        = 1'b0;
      coef_we_d    = 1'b0;
      core_clear_d = 1'b0;
      core_run_d   = 1'b0;
      stat_coef_d  = 1'b0;
      stat_all_d   = 1'b0;
      stat_err_d   = 1'b1;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      scnt_q       <= '0;
      tcnt_q       <= '0;
      sample_en_q  <= 1'b0;
      req_q        <= 1'b0;
      arg_q        <= '0;
      coef_we_q    <= 1'b0;
      coef_idx_q   <= '0;
      coef_data_q  <= '0;
      core_clear_q <= 1'b0;
      core_run_q   <= 1'b0;
      stat_coef_q  <= 1'b0;
      stat_all_q   <= 1'b0;
      stat_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      scnt_q       <= scnt_d;
      tcnt_q       <= tcnt_d;
      sample_en_q  <= sample_en;
      req_q        <= req_d;
      arg_q        <= arg_d;
      coef_we_q    <= coef_we_d;
      coef_idx_q   <= coef_idx_d;
      coef_data_q  <= coef_data_d;
      core_clear_q <= core_clear_d;
      core_run_q   <= core_run_d;
      stat_coef_q  <= stat_coef_d;
      stat_all_q   <= stat_all_d;
      stat_err_q   <= stat_err_d;
      busy_q       <= busy_d;
    end
  end

  assign freq_idx   = idx_q;
  assign cordic_req = req_q;
  assign cordic_arg = arg_q;
  assign coef_we    = coef_we_q;
  assign coef_idx   = coef_idx_q;
  assign coef_data  = coef_data_q;
  assign core_clear = core_clear_q;
  assign core_run   = core_run_q;
  assign stat_coef  = stat_coef_q;
  assign stat_all   = stat_all_q;
  assign stat_err   = stat_err_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule
